// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch-side push port, decode-side pop port,
// flush and occupancy. The slave modport is the buffer's view of the bundle.
interface fetch_decode_buffer_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 2
);
    logic               flush;
    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;
    logic [CNT_W-1:0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// In-order {pc, instr} FIFO between fetch and decode with single-cycle flush.
// Define FETCH_DECODE_BYPASS_EN to pass a pair straight through when empty.
module fetch_decode_buffer #(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_decode_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_empty;
    logic w_byp;
    logic w_byp_take;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);

`ifdef FETCH_DECODE_BYPASS_EN
    assign w_byp = w_empty && !bus.flush;
`else
    assign w_byp = 1'b0;
`endif

    assign bus.in_ready = (r_count != FULL_CNT);
    assign bus.count    = r_count;

    // Head data is masked to zero when empty so unreset storage never leaks out.
    always_comb begin
        bus.out_valid = !w_empty && !bus.flush;
        bus.out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
        bus.out_instr = w_empty ? '0 : r_instr_mem[r_rd_ptr];
        if (w_byp) begin
            bus.out_valid = bus.in_valid;
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end
    end

    // A bypassed pair consumed in the same cycle never occupies an entry.
    assign w_byp_take = w_byp && bus.in_valid && bus.out_ready;
    assign w_push     = bus.in_valid && bus.in_ready && !bus.flush && !w_byp_take;
    assign w_pop      = bus.out_valid && bus.out_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= bus.in_pc;
            r_instr_mem[r_wr_ptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
